// File: rtl/stepper_motion_ctrl_if.sv
// rtl/stepper_motion_ctrl_if.sv - command/status bundle between register file and step sequencer
// Ports (as signals of the bundle):
//   start, abort, dir, num_steps, period_start, period_min, period_dec : command, register file -> sequencer
//   phase, step_pulse, step_cnt, cur_period, busy, done               : status, sequencer -> register file / pins
// Modports: master = register file side, slave = sequencer side.
interface stepper_motion_ctrl_if #(
  parameter int STEP_W = 16,
  parameter int PER_W  = 24
);
  logic              start;
  logic              abort;
  logic              dir;
  logic [STEP_W-1:0] num_steps;
  logic [PER_W-1:0]  period_start;
  logic [PER_W-1:0]  period_min;
  logic [PER_W-1:0]  period_dec;
  logic [3:0]        phase;
  logic              step_pulse;
  logic [STEP_W-1:0] step_cnt;
  logic [PER_W-1:0]  cur_period;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, dir, num_steps, period_start, period_min, period_dec,
    input  phase, step_pulse, step_cnt, cur_period, busy, done
  );

  modport slave (
    input  start, abort, dir, num_steps, period_start, period_min, period_dec,
    output phase, step_pulse, step_cnt, cur_period, busy, done
  );
endinterface

// File: rtl/stepper_motion_ctrl.sv
// rtl/stepper_motion_ctrl.sv - trapezoidal-profile half-step sequencer
// Ports:
//   ACLK    : system clock, rising edge
//   ARESETN : synchronous active-low reset
//   bus     : stepper_motion_ctrl_if.slave (move command in, coil phase and progress out)
// STEP_W / PER_W must match the parameters of the connected interface instance.
module stepper_motion_ctrl #(
  parameter int STEP_W = 16,
  parameter int PER_W  = 24
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  stepper_motion_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCEL, CRUISE, DECEL} state_t;

  state_t            state;
  logic [2:0]        idx;
  logic [3:0]        phase_q;
  logic              step_pulse_q;
  logic [STEP_W-1:0] step_cnt_q;
  logic [PER_W-1:0]  cur_period_q;
  logic              busy_q;
  logic              done_q;
  logic [PER_W-1:0]  timer;
  logic [STEP_W-1:0] ramp;

  // Move parameters captured at start; inputs are not looked at again mid-move.
  logic [STEP_W-1:0] n_q;
  logic              dir_q;
  logic [PER_W-1:0]  pmin_q;
  logic [PER_W-1:0]  pst_q;
  logic [PER_W-1:0]  pdec_q;

  logic [PER_W-1:0]  pmin_in;
  logic [PER_W-1:0]  pst_in;
  logic [STEP_W-1:0] cnt_new;
  logic [STEP_W-1:0] rem;
  logic [PER_W:0]    sum_up;
  logic [PER_W:0]    dif_dn;
  logic [PER_W-1:0]  per_up;
  logic [PER_W-1:0]  per_dn;
  logic [2:0]        idx_step;
  logic              step_now;

  function automatic logic [3:0] phase_of(input logic [2:0] i);
    logic [3:0] p;
    p = 4'b0001;
    case (i)
      3'd0: p = 4'b0001;
      3'd1: p = 4'b0011;
      3'd2: p = 4'b0010;
      3'd3: p = 4'b0110;
      3'd4: p = 4'b0100;
      3'd5: p = 4'b1100;
      3'd6: p = 4'b1000;
      3'd7: p = 4'b1001;
      default: p = 4'b0001;
    endcase
    return p;
  endfunction

  always_comb begin
    pmin_in = (bus.period_min == '0) ? PER_W'(1) : bus.period_min;
    pst_in  = (bus.period_start < pmin_in) ? pmin_in : bus.period_start;

    cnt_new = step_cnt_q + STEP_W'(1);
    rem     = n_q - cnt_new;

    // One extra bit so a large period_dec saturates instead of wrapping.
    sum_up  = {1'b0, cur_period_q} + {1'b0, pdec_q};
    dif_dn  = {1'b0, cur_period_q} - {1'b0, pdec_q};
    per_up  = (sum_up > {1'b0, pst_q}) ? pst_q : sum_up[PER_W-1:0];
    per_dn  = pmin_q;
    if (!dif_dn[PER_W] && (dif_dn[PER_W-1:0] > pmin_q)) begin
      per_dn = dif_dn[PER_W-1:0];
    end

    idx_step = dir_q ? (idx + 3'd1) : (idx - 3'd1);
    // cur_period is at least 1 whenever a move is running, so the subtraction cannot wrap.
    step_now = (timer == (cur_period_q - PER_W'(1)));
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state        <= IDLE;
      idx          <= 3'd0;
      phase_q      <= 4'b0001;
      step_pulse_q <= 1'b0;
      step_cnt_q   <= '0;
      cur_period_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timer        <= '0;
      ramp         <= '0;
      n_q          <= '0;
      dir_q        <= 1'b0;
      pmin_q       <= '0;
      pst_q        <= '0;
      pdec_q       <= '0;
    end else begin
      step_pulse_q <= 1'b0;
      done_q       <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.num_steps == '0) begin
              done_q <= 1'b1;
            end else begin
              n_q          <= bus.num_steps;
              dir_q        <= bus.dir;
              pmin_q       <= pmin_in;
              pst_q        <= pst_in;
              pdec_q       <= bus.period_dec;
              step_cnt_q   <= '0;
              ramp         <= '0;
              timer        <= '0;
              cur_period_q <= pst_in;
              busy_q       <= 1'b1;
              state        <= ACCEL;
            end
          end
        end
        default: begin
          if (step_now) begin
            idx          <= idx_step;
            phase_q      <= phase_of(idx_step);
            step_pulse_q <= 1'b1;
            step_cnt_q   <= cnt_new;
            timer        <= '0;
            // An abort landing on a step edge still lets that step count, then stops once.
            if ((rem == '0) || bus.abort) begin
              state  <= IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else if (rem <= ramp) begin
              // Remaining steps match the accel steps taken: mirror the ramp on the way down.
              state        <= DECEL;
              ramp         <= ramp - STEP_W'(1);
              cur_period_q <= per_up;
            end else if (state == ACCEL) begin
              ramp         <= ramp + STEP_W'(1);
              cur_period_q <= per_dn;
              if (per_dn == pmin_q) begin
                state <= CRUISE;
              end
            end
          end else if (bus.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            timer <= timer + PER_W'(1);
          end
        end
      endcase
    end
  end

  assign bus.phase      = phase_q;
  assign bus.step_pulse = step_pulse_q;
  assign bus.step_cnt   = step_cnt_q;
  assign bus.cur_period = cur_period_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_stepper_motion_ctrl.sv
// tb/tb_stepper_motion_ctrl.sv - table-driven bench for stepper_motion_ctrl
module tb_stepper_motion_ctrl;

  logic aclk;
  logic aresetn;

  stepper_motion_ctrl_if #(.STEP_W(16), .PER_W(24)) bus ();

  stepper_motion_ctrl #(.STEP_W(16), .PER_W(24)) dut (
    .ACLK    (aclk),
    .ARESETN (aresetn),
    .bus     (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [15:0] n;
    logic [23:0] ps;
    logic [23:0] pm;
    logic [23:0] pd;
    logic        dir;
    logic [23:0] exp_pst;
    logic [15:0] exp_total;
  } vec_t;

  vec_t vecs [7];
  int   ivt  [7][12] = '{
    '{5, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0},
    '{8, 6, 4, 4, 4, 4, 4, 4, 6, 8, 0, 0},
    '{8, 6, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0},
    '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0},
    '{6, 6, 6, 6, 0, 0, 0, 0, 0, 0, 0, 0},
    '{5, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0},
    '{10, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0}
  };

  int total_cnt;
  int bad_cnt;
  int exp_idx;

  function automatic logic [3:0] ph(input int i);
    logic [3:0] p;
    case (i)
      0: p = 4'b0001;
      1: p = 4'b0011;
      2: p = 4'b0010;
      3: p = 4'b0110;
      4: p = 4'b0100;
      5: p = 4'b1100;
      6: p = 4'b1000;
      7: p = 4'b1001;
      default: p = 4'bxxxx;
    endcase
    return p;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_cmd(input logic [15:0] n, input logic [23:0] ps, input logic [23:0] pm,
                           input logic [23:0] pd, input logic d);
    bus.num_steps    = n;
    bus.period_start = ps;
    bus.period_min   = pm;
    bus.period_dec   = pd;
    bus.dir          = d;
  endtask

  task automatic step_idx(input logic d);
    exp_idx = d ? (exp_idx + 1) % 8 : (exp_idx + 7) % 8;
  endtask

  task automatic run_vec(input int v);
    int cyc, last, k;
    bit fin;
    @(negedge aclk);
    drive_cmd(vecs[v].n, vecs[v].ps, vecs[v].pm, vecs[v].pd, vecs[v].dir);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk($sformatf("v%0d busy_rise", v), {31'd0, bus.busy}, 32'd1);
    chk($sformatf("v%0d pst", v), {8'd0, bus.cur_period}, {8'd0, vecs[v].exp_pst});
    cyc = 0; last = 0; k = 0; fin = 0;
    while (!fin && cyc < 3000) begin
      tick();
      cyc++;
      if (bus.step_pulse) begin
        step_idx(vecs[v].dir);
        chk($sformatf("v%0d interval%0d", v, k), cyc - last, ivt[v][k]);
        chk($sformatf("v%0d phase%0d", v, k), {28'd0, bus.phase}, {28'd0, ph(exp_idx)});
        k++;
        last = cyc;
        chk($sformatf("v%0d step_cnt%0d", v, k), {16'd0, bus.step_cnt}, k);
      end
      if (bus.done) begin
        fin = 1;
        chk($sformatf("v%0d done_with_step", v), {31'd0, bus.step_pulse}, 32'd1);
        chk($sformatf("v%0d total_cycles", v), cyc, {16'd0, vecs[v].exp_total});
        chk($sformatf("v%0d final_cnt", v), {16'd0, bus.step_cnt}, {16'd0, vecs[v].n});
        chk($sformatf("v%0d busy_fall", v), {31'd0, bus.busy}, 32'd0);
      end
    end
    if (!fin) chk($sformatf("v%0d timeout", v), 32'd0, 32'd1);
    tick();
    chk($sformatf("v%0d done_one_cycle", v), {31'd0, bus.done}, 32'd0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " phase"}, {28'd0, bus.phase}, 32'd1);
    chk({nm, " step_pulse"}, {31'd0, bus.step_pulse}, 32'd0);
    chk({nm, " step_cnt"}, {16'd0, bus.step_cnt}, 32'd0);
    chk({nm, " cur_period"}, {8'd0, bus.cur_period}, 32'd0);
    chk({nm, " busy"}, {31'd0, bus.busy}, 32'd0);
    chk({nm, " done"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    int pulses, cyc, dcount;
    bit busy_seen;

    total_cnt = 0;
    bad_cnt   = 0;
    exp_idx   = 0;

    vecs[0] = '{n: 16'd3,  ps: 24'd5,  pm: 24'd5, pd: 24'd0,        dir: 1'b0, exp_pst: 24'd5,  exp_total: 16'd15};
    vecs[1] = '{n: 16'd10, ps: 24'd8,  pm: 24'd4, pd: 24'd2,        dir: 1'b1, exp_pst: 24'd8,  exp_total: 16'd52};
    vecs[2] = '{n: 16'd3,  ps: 24'd8,  pm: 24'd2, pd: 24'd2,        dir: 1'b1, exp_pst: 24'd8,  exp_total: 16'd22};
    vecs[3] = '{n: 16'd4,  ps: 24'd0,  pm: 24'd0, pd: 24'd0,        dir: 1'b1, exp_pst: 24'd1,  exp_total: 16'd4};
    vecs[4] = '{n: 16'd4,  ps: 24'd6,  pm: 24'd3, pd: 24'd0,        dir: 1'b1, exp_pst: 24'd6,  exp_total: 16'd24};
    vecs[5] = '{n: 16'd3,  ps: 24'd2,  pm: 24'd5, pd: 24'd1,        dir: 1'b1, exp_pst: 24'd5,  exp_total: 16'd15};
    vecs[6] = '{n: 16'd3,  ps: 24'd10, pm: 24'd1, pd: 24'hFFFFFF,   dir: 1'b0, exp_pst: 24'd10, exp_total: 16'd21};

    aresetn   = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    drive_cmd(16'd0, 24'd0, 24'd0, 24'd0, 1'b0);
    tick();
    tick();
    chk_reset_vals("reset");
    @(negedge aclk);
    aresetn = 1'b1;

    for (int v = 0; v < 7; v++) run_vec(v);

    // N=0: one done pulse, busy never asserted
    @(negedge aclk);
    drive_cmd(16'd0, 24'd4, 24'd2, 24'd1, 1'b1);
    bus.start = 1'b1;
    dcount = 0; busy_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.start = 1'b0;
      if (bus.done) dcount++;
      if (bus.busy) busy_seen = 1;
    end
    chk("n0 done_count", dcount, 32'd1);
    chk("n0 busy_seen", {31'd0, busy_seen}, 32'd0);

    // Abort after 2nd step, with an ignored start mid-move
    @(negedge aclk);
    drive_cmd(16'd100, 24'd20, 24'd10, 24'd5, 1'b1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    pulses = 0; cyc = 0;
    while (pulses < 2 && cyc < 200) begin
      tick();
      cyc++;
      if (cyc == 3) begin
        drive_cmd(16'd1, 24'd3, 24'd3, 24'd0, 1'b0);
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.step_pulse) begin
        pulses++;
        step_idx(1'b1);
        if (pulses == 1) chk("abort step1_at", cyc, 32'd20);
        if (pulses == 2) chk("abort step2_at", cyc, 32'd35);
      end
    end
    chk("abort busy_before", {31'd0, bus.busy}, 32'd1);
    tick();
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort busy", {31'd0, bus.busy}, 32'd0);
    chk("abort done", {31'd0, bus.done}, 32'd1);
    chk("abort step_cnt", {16'd0, bus.step_cnt}, 32'd2);
    chk("abort phase", {28'd0, bus.phase}, {28'd0, ph(exp_idx)});
    chk("abort no_step", {31'd0, bus.step_pulse}, 32'd0);
    tick();
    chk("abort done_drop", {31'd0, bus.done}, 32'd0);
    chk("abort cnt_hold", {16'd0, bus.step_cnt}, 32'd2);

    // Abort coincident with the final step
    @(negedge aclk);
    drive_cmd(16'd2, 24'd3, 24'd3, 24'd0, 1'b1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    step_idx(1'b1);
    step_idx(1'b1);
    chk("abfin step_pulse", {31'd0, bus.step_pulse}, 32'd1);
    chk("abfin done", {31'd0, bus.done}, 32'd1);
    chk("abfin step_cnt", {16'd0, bus.step_cnt}, 32'd2);
    chk("abfin busy", {31'd0, bus.busy}, 32'd0);
    chk("abfin phase", {28'd0, bus.phase}, {28'd0, ph(exp_idx)});
    dcount = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.done) dcount++;
    end
    chk("abfin extra_done", dcount, 32'd0);

    // Reset during CRUISE, then a normal move
    @(negedge aclk);
    drive_cmd(16'd10, 24'd8, 24'd4, 24'd2, 1'b1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    pulses = 0; cyc = 0;
    while (pulses < 4 && cyc < 200) begin
      tick();
      cyc++;
      if (bus.step_pulse) pulses++;
    end
    chk("rst_mid reached_cruise", pulses, 32'd4);
    tick();
    aresetn = 1'b0;
    tick();
    chk_reset_vals("rst_mid");
    @(negedge aclk);
    aresetn = 1'b1;
    exp_idx = 0;
    run_vec(2);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stepper_motion_ctrl.md
# stepper_motion_ctrl

Trapezoidal-profile step sequencer for the stepper custom IP. It sits between the AXI4-Lite slave register file and the coil driver pins. It takes a move command (step count, direction, start/minimum period, ramp increment) and produces half-step coil phases with accelerate / cruise / decelerate timing. It reports progress back to the register file.

## Interface
- STEP_W, 16, width of step count and progress counter
- PER_W, 24, width of step period in ACLK cycles
- ACLK  in  1  system clock; all logic rising-edge
- ARESETN  in  1  synchronous, active-low reset
- start  in  1  one-cycle command strobe (from register write)
- abort  in  1  one-cycle stop strobe
- dir  in  1  1 = phase index increments, 0 = decrements
- num_steps  in  STEP_W  steps to issue
- period_start  in  PER_W  cycles per step at ramp start/end
- period_min  in  PER_W  cruise cycles per step
- period_dec  in  PER_W  period change per ramp step
- phase  out  4  coil drive, half-step pattern
- step_pulse  out  1  high one cycle per issued step
- step_cnt  out  STEP_W  steps issued in current/last move
- cur_period  out  PER_W  period of the step being timed
- busy  out  1  move in progress
- done  out  1  one-cycle move-complete/abort pulse

## Operation
- Reset values: phase=4'b0001 (index 0), step_pulse=0, step_cnt=0, cur_period=0, busy=0, done=0, state IDLE.
- Half-step table, index 0..7: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001. Index wraps mod 8 in both directions. Phase holds in IDLE, which gives holding torque.
- Effective parameters are latched at start:
  - Pmin = max(period_min, 1).
  - Pst = max(period_start, Pmin).
  - N = num_steps and direction.
- Inputs are not re-read during a move.
- States: IDLE, ACCEL, CRUISE, DECEL.
- IDLE + start:
  - If N=0: done pulses, nothing else changes.
  - Otherwise: step_cnt=0, ramp=0, timer=0, cur_period=Pst, busy=1, go ACCEL.
- start while busy is ignored.
- Timer increments every cycle in a non-IDLE state. When timer = cur_period-1, a step is issued:
  - phase index ±1.
  - step_pulse=1.
  - step_cnt+1.
  - timer=0.
- After each step, compute R = N - step_cnt_new:
  - R=0: go IDLE, busy=0, done=1. done is coincident with the final step_pulse.
  - else if R ≤ ramp: go DECEL, ramp-1, cur_period = min(cur_period+period_dec, Pst).
  - else if ACCEL: ramp+1, cur_period = max(cur_period-period_dec, Pmin). If result = Pmin, go CRUISE.
  - else (CRUISE): no change.
- Period add/subtract is saturating and computed at PER_W+1 bits. No wrap.
- abort in a non-IDLE state: go IDLE next edge, busy=0, done=1. step_cnt and phase are held.
- abort on the same edge as the final step: the step is counted and a single done pulse is issued.
- abort or start in IDLE with N=0: done pulses (start only). abort in IDLE is ignored.
- period_dec=0: ACCEL never reaches Pmin unless Pst=Pmin. The move runs at Pst, with DECEL bookkeeping only.
- Reset mid-move: all outputs return to reset values on that edge. No done pulse.

## Timing
- start sampled at edge k. The first step_pulse/phase update happens at edge k+Pst.
- Subsequent steps follow at intervals equal to cur_period as updated at the previous step.
- step_pulse, phase, step_cnt, cur_period and done all update on the same edge. They are registered, with no combinational path from inputs.
- busy rises at edge k. busy falls on the final-step edge, or on the edge after abort.
- Accel and decel profiles are symmetric: the ramp counter records accel steps, and DECEL starts when remaining steps equal the accel steps taken.

## Test plan
- Trapezoid: N=10, period_start=8, period_min=4, period_dec=2, dir=1.
  - Step intervals must be 8,6,4,4,4,4,4,4,6,8, for 52 cycles from start to the last step.
  - Phase ends at index 10 mod 8 = 2 (0010).
  - done coincides with the 10th step_pulse.
- Triangle: N=3, start 8, min 2, dec 2. Intervals must be 8,6,8, with CRUISE never entered.
- Direction/wrap: from index 0, N=3 with dir=0, period_start=period_min=5. Phase must sequence 1001, 1000, 1100. Intervals must be 5,5,5.
- Abort: N=100, start 20, min 10, dec 5. Assert abort 3 cycles after the 2nd step_pulse.
  - Next edge: busy=0, done=1, step_cnt=2, phase held.
  - A start issued while the move was busy must have had no effect.
- Boundaries:
  - N=0 start must give a single done pulse with busy never high.
  - period_min=0 with period_start=0 must run at 1-cycle steps.
  - abort coincident with the final step must give exactly one done and step_cnt=N.
- Reset mid-move: drop ARESETN during CRUISE. On the next edge, all outputs must be at reset values and phase=0001. After release, a new start must run normally.
